// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter_if
//  Description : CPU-side request/acknowledge bundle for sram_arbiter.
//                Fetch port (read-only) and data port (read/write).
//                  ireq/iaddr          -> fetch request and word address
//                  irdata/iack         <- fetch read data and completion pulse
//                  dreq/dwrite/daddr   -> data request, direction, address
//                  dwdata              -> data write data
//                  drdata/dack         <- data read data and completion pulse
//                master = CPU side, slave = arbiter side.
//  Revision    : 1.0  initial release
// ============================================================================
interface sram_arbiter_if;
  logic        ireq;
  logic [7:0]  iaddr;
  logic [31:0] irdata;
  logic        iack;
  logic        dreq;
  logic        dwrite;
  logic [7:0]  daddr;
  logic [31:0] dwdata;
  logic [31:0] drdata;
  logic        dack;

  modport master (
    output ireq, iaddr, dreq, dwrite, daddr, dwdata,
    input  irdata, iack, drdata, dack
  );

  modport slave (
    input  ireq, iaddr, dreq, dwrite, daddr, dwdata,
    output irdata, iack, drdata, dack
  );
endinterface
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter
//  Description : Two-port round-robin arbiter and sequencer for a 256x32
//                asynchronous-handshake SRAM (start strobe / done / shared
//                bidirectional data bus). Converts the SRAM pulse-and-done
//                protocol into clocked req/ack transactions, with a watchdog
//                that abandons accesses whose done never arrives.
//  Ports       : clk, rst        clock (rising edge), async active-high reset
//                cpu             fetch + data request ports (slave modport)
//                mem_address     SRAM word address
//                mem_write       SRAM write select
//                mem_start       SRAM start strobe (one cycle)
//                mem_data_io     SRAM data bus, driven only for writes
//                mem_done        SRAM completion, asynchronous
//                busy            high whenever the sequencer is not idle
//                timeout         one-cycle pulse when an access is abandoned
//  Revision    : 1.0  initial release
// ============================================================================
module sram_arbiter #(
  parameter int TIMEOUT = 16,   // WAIT cycles before abandoning, 2..255
  parameter int SETUP   = 1     // address/data setup cycles before start, 1..7
) (
  input  wire logic        clk,
  input  wire logic        rst,
  sram_arbiter_if.slave    cpu,
  output logic [7:0]       mem_address,
  output logic             mem_write,
  output logic             mem_start,
  inout  wire logic [31:0] mem_data_io,
  input  wire logic        mem_done,
  output logic             busy,
  output logic             timeout
);

  localparam logic [2:0] c_setup_last = 3'(SETUP - 1);
  localparam logic [7:0] c_to_last    = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_port;        // granted port: 0 = fetch, 1 = data
  logic        r_ptr;         // round-robin preference: 0 = fetch, 1 = data
  logic [31:0] r_wdata;
  logic        r_drive;       // enables the write-data driver on mem_data_io
  logic [2:0]  r_setup_cnt;
  logic [7:0]  r_to_cnt;
  logic        r_done_s1;
  logic        r_done_s2;
  logic        r_done_s3;

  logic        w_req_any;
  logic        w_grant_d;
  logic        w_done_rise;

  // The SRAM powers up with done high, so only a fresh rising edge counts,
  // and only while an access is actually waiting for it. A late edge from
  // an abandoned access therefore falls outside WAIT and is ignored.
  assign w_done_rise = r_done_s2 & ~r_done_s3 & (r_state == S_WAIT);

  // Data wins when it is the only requester, or when both request and the
  // pointer names data.
  assign w_req_any = cpu.ireq | cpu.dreq;
  assign w_grant_d = cpu.dreq & (~cpu.ireq | r_ptr);

  assign mem_data_io = r_drive ? r_wdata : 32'bz;
  assign busy        = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_port      <= 1'b0;
      r_ptr       <= 1'b0;
      r_wdata     <= 32'd0;
      r_drive     <= 1'b0;
      r_setup_cnt <= 3'd0;
      r_to_cnt    <= 8'd0;
      r_done_s1   <= 1'b0;
      r_done_s2   <= 1'b0;
      r_done_s3   <= 1'b0;
      mem_address <= 8'd0;
      mem_write   <= 1'b0;
      mem_start   <= 1'b0;
      timeout     <= 1'b0;
      cpu.irdata  <= 32'd0;
      cpu.drdata  <= 32'd0;
      cpu.iack    <= 1'b0;
      cpu.dack    <= 1'b0;
    end else begin
      r_done_s1 <= mem_done;
      r_done_s2 <= r_done_s1;
      r_done_s3 <= r_done_s2;

      // single-cycle pulses default low
      cpu.iack <= 1'b0;
      cpu.dack <= 1'b0;
      timeout  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_port <= w_grant_d;
            if (cpu.ireq && cpu.dreq) begin
              r_ptr <= ~w_grant_d;
            end
            // fetch is always a read; write data is only meaningful for data
            r_wdata     <= cpu.dwdata;
            mem_address <= w_grant_d ? cpu.daddr : cpu.iaddr;
            mem_write   <= w_grant_d & cpu.dwrite;
            r_drive     <= w_grant_d & cpu.dwrite;
            r_setup_cnt <= 3'd0;
            r_state     <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (r_setup_cnt == c_setup_last) begin
            mem_start <= 1'b1;
            r_state   <= S_STROBE;
          end else begin
            r_setup_cnt <= r_setup_cnt + 3'd1;
          end
        end

        S_STROBE: begin
          // the SRAM latched the write data on the start edge, so the bus
          // can be released before its read-data window could open
          mem_start <= 1'b0;
          r_drive   <= 1'b0;
          r_to_cnt  <= 8'd0;
          r_state   <= S_WAIT;
        end

        S_WAIT: begin
          if (w_done_rise) begin
            if (!mem_write) begin
              if (r_port) begin
                cpu.drdata <= mem_data_io;
              end else begin
                cpu.irdata <= mem_data_io;
              end
            end
            cpu.iack  <= ~r_port;
            cpu.dack  <= r_port;
            mem_write <= 1'b0;
            r_state   <= S_DONE;
          end else if (r_to_cnt == c_to_last) begin
            timeout   <= 1'b1;
            cpu.iack  <= ~r_port;
            cpu.dack  <= r_port;
            mem_write <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_to_cnt <= r_to_cnt + 8'd1;
          end
        end

        S_DONE: begin
          r_drive <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
